spike_synth: RTL and testbench

Synthetic extracellular-signal source that produces the signed 11-bit sample stream `x` consumed by the spike-detection chain (iir -> enfasi -> detector). It plays a fixed biphasic spike template, scaled by a programmable amplitude, either periodically or on demand. The template is summed with LFSR pseudo-noise and saturated. A ground-truth `spike_true` pulse is emitted alongside each template, so a bench can score detector hits and misses at the other end of the `x` interface.

---
 rtl/spike_synth.sv | 80 ++++++++
 tb/tb_spike_synth.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/spike_synth.sv
// spike_synth: synthetic extracellular source; amplitude-scaled biphasic template plus LFSR noise, saturated to 11 bits.
module spike_synth #(
  parameter int TPL_LEN = 16,
  parameter int NOISE_BITS = 5,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [15:0]        period,
  input  logic [3:0]         amp,
  input  logic               trig,
  output logic signed [10:0] x,
  output logic               spike_true,
  output logic               busy
);
  typedef enum logic {WAIT, PLAY} state_t;
  localparam logic signed [9:0] TPL [16] = '{
    10'sd0, 10'sd40, 10'sd120, 10'sd240, 10'sd320, 10'sd200, 10'sd0, -10'sd160,
    -10'sd280, -10'sd320, -10'sd260, -10'sd180, -10'sd110, -10'sd60, -10'sd25, -10'sd8};
  state_t             state_q;
  logic [15:0]        lfsr_q, lfsr_d, cnt_q;
  logic [3:0]         idx_q;
  logic signed [10:0] x_q, x_d;
  logic               spike_q, busy_q, hit;
  logic signed [9:0]  tpl;
  logic signed [14:0] prod;
  logic signed [11:0] s;
  logic signed [12:0] noise, sum;
  generate
    if (NOISE_BITS == 0) begin : g_quiet
      assign noise = '0;
    end else begin : g_noise
      assign noise = 13'(signed'(lfsr_q[NOISE_BITS-1:0]));
    end
  endgenerate
  always_comb begin
    tpl    = (state_q == PLAY) ? TPL[idx_q] : '0;
    prod   = tpl * $signed({1'b0, amp});
    s      = 12'(prod >>> 3);
    sum    = {s[11], s} + noise;
    x_d    = (sum > 13'sd1023) ? 11'sd1023 : (sum < -13'sd1024) ? -11'sd1024 : sum[10:0];
    lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
    hit    = (period != '0) && (cnt_q == period - 16'd1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT;
      lfsr_q  <= LFSR_SEED;
      cnt_q   <= '0;
      idx_q   <= '0;
      x_q     <= '0;
      spike_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (enable) begin
      lfsr_q  <= lfsr_d;
      x_q     <= x_d;
      spike_q <= (state_q == PLAY) && (idx_q == '0);
      busy_q  <= (state_q == PLAY);
      if (state_q == WAIT) begin
        if (trig || hit) begin
          state_q <= PLAY;
          idx_q   <= '0;
          cnt_q   <= '0;
        end else begin
          cnt_q <= (period == '0) ? '0 : cnt_q + 16'd1;
        end
      end else begin
        idx_q <= idx_q + 4'd1;
        if (idx_q == 4'(TPL_LEN - 1)) begin
          state_q <= WAIT;
          cnt_q   <= '0;
        end
      end
    end
  end
  assign x          = x_q;
  assign spike_true = spike_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_spike_synth.sv
// tb_spike_synth: directed checks on a noiseless and a default-noise instance sharing one stimulus.
module tb_spike_synth;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b1, trig = 1'b0;
  logic [15:0] period = '0;
  logic [3:0] amp = 4'd8;
  logic signed [10:0] x0, xn;
  logic sp0, spn, b0, bn;
  int pass = 0, total = 0;
  int tpl[16] = '{0, 40, 120, 240, 320, 200, 0, -160, -280, -320, -260, -180, -110, -60, -25, -8};
  int nz[7] = '{1, -16, -8, -4, 14, 7, -13};
  spike_synth #(.NOISE_BITS(0)) dut0 (.clk(clk), .rst(rst), .enable(enable), .period(period),
    .amp(amp), .trig(trig), .x(x0), .spike_true(sp0), .busy(b0));
  spike_synth dutn (.clk(clk), .rst(rst), .enable(enable), .period(period),
    .amp(amp), .trig(trig), .x(xn), .spike_true(spn), .busy(bn));
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    step;
    step;
    total++; if (x0 !== 11'sd0 || xn !== 11'sd0) $display("FAIL reset_x got %0d/%0d want 0", x0, xn); else pass++;
    total++; if ({sp0, spn, b0, bn} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {sp0, spn, b0, bn}); else pass++;
    rst = 1'b0;
  endtask
  task automatic test_noise;
    int bad;
    amp = 4'd0;
    for (int i = 0; i < 7; i++) begin
      step;
      total++; if (xn !== nz[i]) $display("FAIL noise_seq[%0d] got %0d want %0d", i, xn, nz[i]); else pass++;
    end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step;
      if (xn < -16 || xn > 15) bad++;
    end
    total++; if (bad != 0) $display("FAIL noise_range got %0d out-of-range want 0", bad); else pass++;
  endtask
  task automatic test_template;
    amp = 4'd8;
    period = '0;
    trig = 1'b1;
    step;
    trig = 1'b0;
    total++; if (x0 !== 11'sd0 || b0 !== 1'b0) $display("FAIL tpl_pre got x=%0d busy=%b want 0/0", x0, b0); else pass++;
    for (int i = 0; i < 16; i++) begin
      step;
      total++; if (x0 !== tpl[i]) $display("FAIL tpl_x[%0d] got %0d want %0d", i, x0, tpl[i]); else pass++;
      total++; if (b0 !== 1'b1 || sp0 !== (i == 0)) $display("FAIL tpl_flags[%0d] got busy=%b spike=%b want 1/%b", i, b0, sp0, i == 0); else pass++;
    end
    step;
    total++; if (x0 !== 11'sd0 || b0 !== 1'b0 || sp0 !== 1'b0) $display("FAIL tpl_post got x=%0d busy=%b spike=%b want 0/0/0", x0, b0, sp0); else pass++;
  endtask
  task automatic test_amp;
    amp = 4'd15;
    trig = 1'b1;
    step;
    trig = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step;
      if (i == 4) begin total++; if (x0 !== 11'sd600) $display("FAIL amp15_peak got %0d want 600", x0); else pass++; end
      if (i == 9) begin total++; if (x0 !== -11'sd600) $display("FAIL amp15_trough got %0d want -600", x0); else pass++; end
    end
    amp = 4'd3;
    step;
    trig = 1'b1;
    step;
    trig = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step;
      if (i == 1) begin total++; if (x0 !== 11'sd15) $display("FAIL amp3_idx1 got %0d want 15", x0); else pass++; end
      if (i == 14) begin total++; if (x0 !== -11'sd10) $display("FAIL amp3_floor got %0d want -10", x0); else pass++; end
    end
    step;
  endtask
  task automatic test_periodic;
    int n, k, bad;
    int rises[2];
    logic prev_sp;
    logic signed [10:0] prev_x;
    amp = 4'd8;
    period = 16'd100;
    n = 0;
    do begin step; n++; end while (!sp0 && n < 400);
    n = 0;
    do begin step; n++; end while (!sp0 && n < 400);
    total++; if (n != 116) $display("FAIL periodic_spacing got %0d want 116", n); else pass++;
    k = 0;
    bad = 0;
    rises = '{0, 0};
    for (int i = 0; i < 800 && k < 2; i++) begin
      prev_x = x0;
      prev_sp = sp0;
      enable = (i % 2 == 0);
      step;
      if (!enable && x0 !== prev_x) bad++;
      if (sp0 && !prev_sp) begin rises[k] = i; k++; end
    end
    enable = 1'b1;
    total++; if (k != 2 || rises[1] - rises[0] != 232) $display("FAIL toggled_spacing got %0d (pulses %0d) want 232", rises[1] - rises[0], k); else pass++;
    total++; if (bad != 0) $display("FAIL freeze got %0d changes want 0", bad); else pass++;
    period = '0;
    n = 0;
    do begin step; n++; end while (b0 && n < 40);
    step;
  endtask
  task automatic test_back_to_back;
    int nb, ns, n;
    trig = 1'b1;
    step;
    nb = 0;
    ns = 0;
    for (int i = 0; i < 24; i++) begin
      trig = (i < 15);
      step;
      nb += b0;
      ns += sp0;
    end
    total++; if (nb != 16 || ns != 1) $display("FAIL trig_in_play got busy=%0d spikes=%0d want 16/1", nb, ns); else pass++;
    period = 16'd20;
    n = 0;
    do begin step; n++; end while (!sp0 && n < 100);
    for (int i = 1; i < 35; i++) step;
    trig = 1'b1;
    step;
    trig = 1'b0;
    nb = 0;
    ns = 0;
    for (int i = 0; i < 26; i++) begin
      step;
      if (i == 0) begin total++; if (sp0 !== 1'b1) $display("FAIL coincide_start got %b want 1", sp0); else pass++; end
      nb += b0;
      ns += sp0;
    end
    total++; if (nb != 16 || ns != 1) $display("FAIL coincide got busy=%0d spikes=%0d want 16/1", nb, ns); else pass++;
    period = '0;
    n = 0;
    do begin step; n++; end while (b0 && n < 40);
    step;
  endtask
  task automatic test_reset_mid;
    amp = 4'd8;
    trig = 1'b1;
    step;
    trig = 1'b0;
    repeat (8) step;
    total++; if (x0 !== -11'sd160 || b0 !== 1'b1) $display("FAIL mid_idx7 got x=%0d busy=%b want -160/1", x0, b0); else pass++;
    rst = 1'b1;
    step;
    rst = 1'b0;
    total++; if (x0 !== 11'sd0 || xn !== 11'sd0 || {sp0, spn, b0, bn} !== 4'b0) $display("FAIL mid_reset got x=%0d/%0d flags=%b want 0/0/0000", x0, xn, {sp0, spn, b0, bn}); else pass++;
    amp = 4'd0;
    for (int i = 0; i < 7; i++) begin
      step;
      total++; if (xn !== nz[i] || bn !== 1'b0) $display("FAIL mid_noise[%0d] got %0d busy=%b want %0d/0", i, xn, bn, nz[i]); else pass++;
    end
  endtask
  initial begin
    test_reset;
    test_noise;
    test_template;
    test_amp;
    test_periodic;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
